// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// axil_cmd_master : single-command AXI4-Lite master (write / read / poll-read)
// Revision: 1.0
// ============================================================================
module axil_cmd_master #(
    parameter int C_M00_AXI_ADDR_WIDTH = 6,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int POLL_BIT             = 16
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_aresetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic                              cmd_poll,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_mask,
    output logic                              rsp_valid,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4,
        CHK  = 3'd5,
        RSP  = 3'd6
    } state_t;

    localparam logic [POLL_BIT-1:0] POLL_MAX = '1;
    localparam logic [POLL_BIT-1:0] POLL_ONE = {{(POLL_BIT-1){1'b0}}, 1'b1};

    state_t                            state_q, state_d;
    logic                              init_q;
    logic                              poll_q;
    logic [C_M00_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M00_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M00_AXI_DATA_WIDTH-1:0]   mask_q;
    logic                              aw_done_q;
    logic                              w_done_q;
    logic [C_M00_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                        resp_q;
    logic [POLL_BIT-1:0]               poll_cnt_q;
    logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]                        rsp_resp_q;
    logic                              rsp_timeout_q;

    logic w_accept;
    logic w_poll_match;
    logic w_poll_stop;
    logic w_poll_timeout;

    assign w_accept       = (state_q == IDLE) && init_q && cmd_valid;
    assign w_poll_match   = ((rdata_q ^ wdata_q) & mask_q) == '0;
    // An error response ends polling just like a match; only a clean mismatch at the limit is a timeout.
    assign w_poll_stop    = w_poll_match || (resp_q != 2'b00) || (poll_cnt_q == POLL_MAX);
    assign w_poll_timeout = !w_poll_match && (resp_q == 2'b00) && (poll_cnt_q == POLL_MAX);

    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_wdata  = wdata_q;
    assign m00_axi_wstrb  = '1;
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Valids/readies decode from registered state only, so no ready-to-valid path exists.
    always_comb begin
        state_d         = state_q;
        cmd_ready       = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        rsp_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = init_q;
                if (w_accept) state_d = cmd_write ? WR : RA;
            end
            WR: begin
                m00_axi_awvalid = !aw_done_q;
                m00_axi_wvalid  = !w_done_q;
                if ((aw_done_q || m00_axi_awready) && (w_done_q || m00_axi_wready)) state_d = WB;
            end
            WB: begin
                m00_axi_bready = 1'b1;
                if (m00_axi_bvalid) state_d = RSP;
            end
            RA: begin
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) state_d = RD;
            end
            RD: begin
                m00_axi_rready = 1'b1;
                if (m00_axi_rvalid) state_d = poll_q ? CHK : RSP;
            end
            CHK: begin
                state_d = w_poll_stop ? RSP : RA;
            end
            RSP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            init_q        <= 1'b0;
            poll_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rdata_q       <= '0;
            resp_q        <= 2'b00;
            poll_cnt_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        addr_q        <= cmd_addr;
                        wdata_q       <= cmd_wdata;
                        mask_q        <= cmd_mask;
                        poll_q        <= cmd_poll && !cmd_write;
                        aw_done_q     <= 1'b0;
                        w_done_q      <= 1'b0;
                        poll_cnt_q    <= '0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                WR: begin
                    if (m00_axi_awvalid && m00_axi_awready) aw_done_q <= 1'b1;
                    if (m00_axi_wvalid && m00_axi_wready)   w_done_q  <= 1'b1;
                end
                WB: begin
                    if (m00_axi_bvalid) begin
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= m00_axi_bresp;
                    end
                end
                RD: begin
                    if (m00_axi_rvalid) begin
                        rdata_q <= m00_axi_rdata;
                        resp_q  <= m00_axi_rresp;
                        if (poll_q && (poll_cnt_q != POLL_MAX)) poll_cnt_q <= poll_cnt_q + POLL_ONE;
                        // Plain reads publish immediately; polls publish only when CHK finishes.
                        if (!poll_q) begin
                            rsp_rdata_q <= m00_axi_rdata;
                            rsp_resp_q  <= m00_axi_rresp;
                        end
                    end
                end
                CHK: begin
                    if (w_poll_stop) begin
                        rsp_rdata_q   <= rdata_q;
                        rsp_resp_q    <= resp_q;
                        rsp_timeout_q <= w_poll_timeout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_axil_cmd_master : directed self-checking bench for axil_cmd_master
// Revision: 1.0
// ============================================================================
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata, cmd_mask;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  m00_axi_awaddr, m00_axi_araddr;
    logic [2:0]  m00_axi_awprot, m00_axi_arprot;
    logic        m00_axi_awvalid, m00_axi_awready, m00_axi_wvalid, m00_axi_wready;
    logic [31:0] m00_axi_wdata, m00_axi_rdata;
    logic [3:0]  m00_axi_wstrb;
    logic [1:0]  m00_axi_bresp, m00_axi_rresp;
    logic        m00_axi_bvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_arready;
    logic        m00_axi_rvalid, m00_axi_rready;

    axil_cmd_master #(
        .C_M00_AXI_ADDR_WIDTH (6),
        .C_M00_AXI_DATA_WIDTH (32),
        .POLL_BIT             (3)
    ) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_poll        (cmd_poll),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_mask        (cmd_mask),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .rsp_timeout     (rsp_timeout),
        .m00_axi_awaddr  (m00_axi_awaddr),
        .m00_axi_awprot  (m00_axi_awprot),
        .m00_axi_awvalid (m00_axi_awvalid),
        .m00_axi_awready (m00_axi_awready),
        .m00_axi_wdata   (m00_axi_wdata),
        .m00_axi_wstrb   (m00_axi_wstrb),
        .m00_axi_wvalid  (m00_axi_wvalid),
        .m00_axi_wready  (m00_axi_wready),
        .m00_axi_bresp   (m00_axi_bresp),
        .m00_axi_bvalid  (m00_axi_bvalid),
        .m00_axi_bready  (m00_axi_bready),
        .m00_axi_araddr  (m00_axi_araddr),
        .m00_axi_arprot  (m00_axi_arprot),
        .m00_axi_arvalid (m00_axi_arvalid),
        .m00_axi_arready (m00_axi_arready),
        .m00_axi_rdata   (m00_axi_rdata),
        .m00_axi_rresp   (m00_axi_rresp),
        .m00_axi_rvalid  (m00_axi_rvalid),
        .m00_axi_rready  (m00_axi_rready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Slave behaviour knobs, written only by the main sequence.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [31:0] rd_seq [16];
    logic [1:0]  rr_seq [16];
    logic [3:0]  rd_idx = 4'd0;

    initial begin
        int cnt;
        cnt = 0;
        m00_axi_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (m00_axi_awvalid && !m00_axi_awready) begin
                if (cnt >= aw_dly) begin m00_axi_awready = 1'b1; cnt = 0; end
                else cnt++;
            end else begin
                m00_axi_awready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        m00_axi_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (m00_axi_wvalid && !m00_axi_wready) begin
                if (cnt >= w_dly) begin m00_axi_wready = 1'b1; cnt = 0; end
                else cnt++;
            end else begin
                m00_axi_wready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        m00_axi_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (m00_axi_arvalid && !m00_axi_arready) begin
                if (cnt >= ar_dly) begin m00_axi_arready = 1'b1; cnt = 0; end
                else cnt++;
            end else begin
                m00_axi_arready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        m00_axi_bvalid = 1'b0;
        m00_axi_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (m00_axi_bvalid) begin
                m00_axi_bvalid = 1'b0;
                m00_axi_bresp  = 2'b00;
            end else if (m00_axi_bready) begin
                if (cnt >= b_dly) begin
                    m00_axi_bvalid = 1'b1;
                    m00_axi_bresp  = b_resp_cfg;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        m00_axi_rvalid = 1'b0;
        m00_axi_rdata  = '0;
        m00_axi_rresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (m00_axi_rvalid) begin
                m00_axi_rvalid = 1'b0;
            end else if (m00_axi_rready) begin
                if (cnt >= r_dly) begin
                    m00_axi_rvalid = 1'b1;
                    m00_axi_rdata  = rd_seq[rd_idx];
                    m00_axi_rresp  = rr_seq[rd_idx];
                    rd_idx         = rd_idx + 4'd1;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Sampled just before each rising edge: what the DUT and slave see at that edge.
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, rsp_cnt = 0, viol = 0;
    logic [5:0]  last_awaddr = '0, last_araddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    initial begin
        logic       p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br, p_bv;
        logic [5:0] p_awa, p_ara;
        logic [31:0] p_wd;
        p_rst = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
        p_arv = 1'b0; p_arr = 1'b0; p_br = 1'b0; p_bv = 1'b0;
        p_awa = '0; p_ara = '0; p_wd = '0;
        forever begin
            @(negedge clk);
            #3;
            if (m00_axi_awvalid && m00_axi_awready) begin aw_hs++; last_awaddr = m00_axi_awaddr; end
            if (m00_axi_wvalid && m00_axi_wready) begin
                w_hs++; last_wdata = m00_axi_wdata; last_wstrb = m00_axi_wstrb;
            end
            if (m00_axi_arvalid && m00_axi_arready) begin ar_hs++; last_araddr = m00_axi_araddr; end
            if (rsp_valid) rsp_cnt++;
            if (rst_n && p_rst) begin
                if (p_awv && !p_awr && (!m00_axi_awvalid || m00_axi_awaddr != p_awa)) viol++;
                if (p_wv && !p_wr && (!m00_axi_wvalid || m00_axi_wdata != p_wd)) viol++;
                if (p_arv && !p_arr && (!m00_axi_arvalid || m00_axi_araddr != p_ara)) viol++;
                if (p_br && !p_bv && !m00_axi_bready) viol++;
            end
            p_rst = rst_n;
            p_awv = m00_axi_awvalid; p_awr = m00_axi_awready; p_awa = m00_axi_awaddr;
            p_wv  = m00_axi_wvalid;  p_wr  = m00_axi_wready;  p_wd  = m00_axi_wdata;
            p_arv = m00_axi_arvalid; p_arr = m00_axi_arready; p_ara = m00_axi_araddr;
            p_br  = m00_axi_bready;  p_bv  = m00_axi_bvalid;
        end
    end

    task automatic run_cmd(input logic wr, input logic poll, input logic [5:0] addr,
                           input logic [31:0] wd, input logic [31:0] mk,
                           output int lat, output logic [31:0] rd,
                           output logic [1:0] rs, output logic to);
        int n;
        lat = -1; rd = '0; rs = 2'b00; to = 1'b0; n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        cmd_write = wr; cmd_poll = poll; cmd_addr = addr;
        cmd_wdata = wd; cmd_mask = mk; cmd_valid = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                lat = i; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
                break;
            end
        end
        @(negedge clk);
        check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, aw0, w0, ar0, rc0;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        logic [3:0]  base;

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        for (int i = 0; i < 16; i++) begin rd_seq[i] = '0; rr_seq[i] = 2'b00; end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_valids", 32'({m00_axi_awvalid, m00_axi_wvalid, m00_axi_arvalid,
                                 m00_axi_bready, m00_axi_rready}), 32'd0);
        check("rst_rsp_out", 32'({rsp_timeout, rsp_resp}) | rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        // Zero-wait write and read latency
        run_cmd(1'b1, 1'b0, 6'h04, 32'h1234_5678, 32'h0, lat, rd, rs, to);
        check("wr0_lat", 32'(lat), 32'd3);
        check("wr0_awaddr", 32'(last_awaddr), 32'h04);
        check("wr0_wdata", last_wdata, 32'h1234_5678);
        check("wr0_wstrb", 32'(last_wstrb), 32'hF);
        check("wr0_rdata", rd, 32'h0);

        base = rd_idx;
        rd_seq[base] = 32'h0BAD_F00D;
        run_cmd(1'b0, 1'b0, 6'h10, 32'h0, 32'h0, lat, rd, rs, to);
        check("rd0_lat", 32'(lat), 32'd3);
        check("rd0_rdata", rd, 32'h0BAD_F00D);

        // Write, awready two cycles ahead of wready, slow bvalid
        aw_dly = 0; w_dly = 2; b_dly = 3;
        aw0 = aw_hs; w0 = w_hs; rc0 = rsp_cnt;
        run_cmd(1'b1, 1'b0, 6'h00, 32'h0000_0001, 32'h0, lat, rd, rs, to);
        repeat (2) @(negedge clk);
        check("wr1_lat", 32'(lat), 32'd8);
        check("wr1_aw_hs", 32'(aw_hs - aw0), 32'd1);
        check("wr1_w_hs", 32'(w_hs - w0), 32'd1);
        check("wr1_rsp_cnt", 32'(rsp_cnt - rc0), 32'd1);
        check("wr1_resp", 32'(rs), 32'd0);
        check("wr1_awaddr", 32'(last_awaddr), 32'h00);
        check("wr1_wdata", last_wdata, 32'h1);
        w_dly = 0; b_dly = 0;

        // Read with arready and rvalid delays
        ar_dly = 2; r_dly = 4;
        ar0 = ar_hs; base = rd_idx;
        rd_seq[base] = 32'hDEAD_BEEF;
        run_cmd(1'b0, 1'b0, 6'h0C, 32'h0, 32'h0, lat, rd, rs, to);
        check("rd1_lat", 32'(lat), 32'd9);
        check("rd1_rdata", rd, 32'hDEAD_BEEF);
        check("rd1_araddr", 32'(last_araddr), 32'h0C);
        check("rd1_ar_hs", 32'(ar_hs - ar0), 32'd1);
        ar_dly = 0; r_dly = 0;

        // Poll: done bit appears on the third read
        ar0 = ar_hs; base = rd_idx;
        rd_seq[base]        = 32'h0000_0000;
        rd_seq[base + 4'd1] = 32'h0000_0003;
        rd_seq[base + 4'd2] = 32'h0000_0007;
        run_cmd(1'b0, 1'b1, 6'h08, 32'h4, 32'h4, lat, rd, rs, to);
        check("poll_ar_hs", 32'(ar_hs - ar0), 32'd3);
        check("poll_lat", 32'(lat), 32'd10);
        check("poll_rdata", rd, 32'h0000_0007);
        check("poll_timeout", 32'(to), 32'd0);

        // Poll that never matches: limit 2^3-1 reads
        ar0 = ar_hs; base = rd_idx;
        for (int i = 0; i < 7; i++) rd_seq[base + 4'(i)] = 32'hA000_0000 + 32'(2 * i);
        rd_seq[base + 4'd7] = 32'h0000_0001;
        run_cmd(1'b0, 1'b1, 6'h08, 32'h1, 32'h1, lat, rd, rs, to);
        check("tmo_ar_hs", 32'(ar_hs - ar0), 32'd7);
        check("tmo_flag", 32'(to), 32'd1);
        check("tmo_rdata", rd, 32'hA000_000C);
        check("tmo_resp", 32'(rs), 32'd0);
        check("tmo_lat", 32'(lat), 32'd22);
        repeat (3) @(negedge clk);
        check("tmo_hold_rdata", rsp_rdata, 32'hA000_000C);
        check("tmo_hold_flag", 32'(rsp_timeout), 32'd1);

        // Poll stopped by DECERR on the first read
        ar0 = ar_hs; base = rd_idx;
        rd_seq[base] = 32'h0; rr_seq[base] = 2'b11;
        run_cmd(1'b0, 1'b1, 6'h08, 32'h1, 32'h1, lat, rd, rs, to);
        check("err_poll_ar_hs", 32'(ar_hs - ar0), 32'd1);
        check("err_poll_resp", 32'(rs), 32'd3);
        check("err_poll_timeout", 32'(to), 32'd0);
        rr_seq[base] = 2'b00;

        // Write with SLVERR
        b_resp_cfg = 2'b10;
        run_cmd(1'b1, 1'b0, 6'h20, 32'hFFFF_0000, 32'h0, lat, rd, rs, to);
        check("slverr_resp", 32'(rs), 32'd2);
        check("slverr_rdata", rd, 32'h0);
        b_resp_cfg = 2'b00;

        // Reset while awvalid is pending
        aw_dly = 6; w_dly = 6;
        aw0 = aw_hs; rc0 = rsp_cnt;
        @(negedge clk);
        cmd_write = 1'b1; cmd_poll = 1'b0; cmd_addr = 6'h14; cmd_wdata = 32'h55; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_awvalid_pre", 32'(m00_axi_awvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_awvalid_rst", 32'(m00_axi_awvalid), 32'd0);
        check("mid_wvalid_rst", 32'(m00_axi_wvalid), 32'd0);
        check("mid_ready_rst", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        aw_dly = 0; w_dly = 0;
        repeat (3) @(negedge clk);
        check("mid_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
        check("mid_no_aw_hs", 32'(aw_hs - aw0), 32'd0);
        check("mid_ready_after", 32'(cmd_ready), 32'd1);
        run_cmd(1'b1, 1'b0, 6'h18, 32'h0000_CAFE, 32'h0, lat, rd, rs, to);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_resp", 32'(rs), 32'd0);
        check("post_rst_wdata", last_wdata, 32'h0000_CAFE);

        repeat (2) @(negedge clk);
        check("protocol_viol", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
